lighting_ramp_ctrl: RTL and testbench



---
 rtl/lighting_ramp_ctrl.sv | 148 ++++++++++++++
 tb/tb_lighting_ramp_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lighting_ramp_ctrl.sv
// Purpose: soft-start/soft-stop lamp-count and shade-level ramp controller fed by a valid/ready request.
// Latency: LOAD on the cycle after accept; ramp steps every RAMP_DIV cycles, done pulses the cycle after the last step.
// Backpressure: req_ready low in LOAD/DONE; an accept during RAMP retargets. Macro LRC_GRADUAL_EN enables ramping (else direct jump).
module lighting_ramp_ctrl #(
  parameter int LAMPS    = 16,
  parameter int CW       = $clog2(LAMPS + 1),
  parameter int SW       = 4,
  parameter int RAMP_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CW-1:0]     req_lamps,
  input  logic [SW-1:0]     req_shade,
  output logic [CW-1:0]     lightnum,
  output logic [LAMPS-1:0]  lightstate,
  output logic [SW-1:0]     wshade,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, LOAD, RAMP, DONE} state_t;

  localparam logic [CW-1:0] LAMPS_MAX = CW'(LAMPS);

  // A zero divider has no meaningful tick period; keep the parameter referenced in every build.
  if (RAMP_DIV < 1) begin : g_bad_ramp_div
  end

  state_t         state, state_nxt;
  logic [CW-1:0]  lamps_nxt, tgt_lamps, tgt_lamps_nxt;
  logic [SW-1:0]  shade_nxt, tgt_shade, tgt_shade_nxt;
  logic [CW-1:0]  req_lamps_clamped;
  logic           accept;

  assign accept            = req_valid & req_ready;
  assign req_lamps_clamped = (req_lamps > LAMPS_MAX) ? LAMPS_MAX : req_lamps;

`ifdef LRC_GRADUAL_EN
  localparam int            PW         = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);

  logic [PW-1:0]  presc, presc_nxt;
  logic [CW-1:0]  lamps_step;
  logic [SW-1:0]  shade_step;

  // One unit toward each target; an axis at its target holds, so no overshoot or wrap.
  always_comb begin
    lamps_step = lightnum;
    shade_step = wshade;
    if (lightnum < tgt_lamps)      lamps_step = lightnum + 1'b1;
    else if (lightnum > tgt_lamps) lamps_step = lightnum - 1'b1;
    if (wshade < tgt_shade)        shade_step = wshade + 1'b1;
    else if (wshade > tgt_shade)   shade_step = wshade - 1'b1;
  end

  // Prescaler register: only ticks while ramping, cleared by LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc <= '0;
    else        presc <= presc_nxt;
  end
`endif

  // Next-state and datapath updates; targets are captured on the accepting edge itself.
  always_comb begin
    state_nxt     = state;
    lamps_nxt     = lightnum;
    shade_nxt     = wshade;
    tgt_lamps_nxt = tgt_lamps;
    tgt_shade_nxt = tgt_shade;
`ifdef LRC_GRADUAL_EN
    presc_nxt     = presc;
`endif
    unique case (state)
      IDLE: begin
        if (accept) begin
          tgt_lamps_nxt = req_lamps_clamped;
          tgt_shade_nxt = req_shade;
          state_nxt     = LOAD;
        end
      end
      LOAD: begin
`ifdef LRC_GRADUAL_EN
        presc_nxt = '0;
        if (lightnum == tgt_lamps && wshade == tgt_shade) state_nxt = DONE;
        else                                              state_nxt = RAMP;
`else
        lamps_nxt = tgt_lamps;
        shade_nxt = tgt_shade;
        state_nxt = DONE;
`endif
      end
      RAMP: begin
`ifdef LRC_GRADUAL_EN
        // A new request wins over a coincident tick; ramping resumes from the current values.
        if (accept) begin
          tgt_lamps_nxt = req_lamps_clamped;
          tgt_shade_nxt = req_shade;
          state_nxt     = LOAD;
        end else if (presc == PRESC_LAST) begin
          presc_nxt = '0;
          lamps_nxt = lamps_step;
          shade_nxt = shade_step;
          if (lamps_step == tgt_lamps && shade_step == tgt_shade) state_nxt = DONE;
        end else begin
          presc_nxt = presc + 1'b1;
        end
`else
        state_nxt = IDLE;
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, current outputs and latched targets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lightnum  <= '0;
      wshade    <= '0;
      tgt_lamps <= '0;
      tgt_shade <= '0;
    end else begin
      state     <= state_nxt;
      lightnum  <= lamps_nxt;
      wshade    <= shade_nxt;
      tgt_lamps <= tgt_lamps_nxt;
      tgt_shade <= tgt_shade_nxt;
    end
  end

  // Thermometer lamp enables derived from the registered count.
  always_comb begin
    lightstate = '0;
    for (int i = 0; i < LAMPS; i++) lightstate[i] = (32'(i) < 32'(lightnum));
  end

  // Status decoded from the state register.
  always_comb begin
    req_ready = (state == IDLE) || (state == RAMP);
    busy      = (state == LOAD) || (state == RAMP);
    done      = (state == DONE);
  end

endmodule

// File: tb/tb_lighting_ramp_ctrl.sv
// Purpose: directed self-checking bench for lighting_ramp_ctrl (LAMPS=16, RAMP_DIV=4).
// Latency: follows each request edge-by-edge against hand-computed step times.
// Backpressure: requests wait for req_ready with a bounded cycle budget.
module tb_lighting_ramp_ctrl;

  localparam int LAMPS = 16;
  localparam int CW    = 5;
  localparam int SW    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [CW-1:0]    req_lamps = '0;
  logic [SW-1:0]    req_shade = '0;
  logic [CW-1:0]    lightnum;
  logic [LAMPS-1:0] lightstate;
  logic [SW-1:0]    wshade;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  lighting_ramp_ctrl #(.LAMPS(LAMPS), .CW(CW), .SW(SW), .RAMP_DIV(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_lamps  (req_lamps),
    .req_shade  (req_shade),
    .lightnum   (lightnum),
    .lightstate (lightstate),
    .wshade     (wshade),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the accepting edge (state is LOAD).
  task automatic send(input logic [CW-1:0] l, input logic [SW-1:0] s);
    int n;
    req_lamps = l;
    req_shade = s;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    check("req_ready_wait", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_lightnum"},   32'(lightnum),   32'd0);
    check({tag, "_wshade"},     32'(wshade),     32'd0);
    check({tag, "_lightstate"}, 32'(lightstate), 32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_ready"},      32'(req_ready),  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #22;
    rst_n = 1'b1;
    tick();
    check_idle_zero("reset");

`ifdef LRC_GRADUAL_EN
    // Basic ramp to 5 lamps, shade 2.
    send(5'd5, 4'd2);
    check("basic_load_busy",  32'(busy),      32'd1);
    check("basic_load_ready", 32'(req_ready), 32'd0);
    tick();
    for (int k = 1; k <= 5; k++) begin
      repeat (3) tick();
      check("basic_pre_step", 32'(lightnum), 32'(k - 1));
      tick();
      check("basic_lightnum",   32'(lightnum),   32'(k));
      check("basic_wshade",     32'(wshade),     32'((k < 2) ? k : 2));
      check("basic_lightstate", 32'(lightstate), (32'd1 << k) - 32'd1);
      check("basic_done",       32'(done),       32'(k == 5));
    end
    tick();
    check("basic_done_clear", 32'(done),       32'd0);
    check("basic_idle_busy",  32'(busy),       32'd0);
    check("basic_final_ls",   32'(lightstate), 32'h001F);

    // Clamp: 20 lamps requested, 16 available; shade to full scale.
    do_reset();
    send(5'd20, 4'd15);
    tick();
    for (int k = 1; k <= 16; k++) begin
      repeat (4) tick();
      check("clamp_lightnum", 32'(lightnum), 32'(k));
      check("clamp_wshade",   32'(wshade),   32'((k < 15) ? k : 15));
      check("clamp_done",     32'(done),     32'(k == 16));
    end
    check("clamp_lightstate", 32'(lightstate), 32'hFFFF);

    // Retarget from 3 (heading to 10) down to 1.
    do_reset();
    send(5'd10, 4'd0);
    repeat (13) tick();
    check("retgt_at3", 32'(lightnum), 32'd3);
    send(5'd1, 4'd0);
    check("retgt_load_busy",  32'(busy),      32'd1);
    check("retgt_load_ready", 32'(req_ready), 32'd0);
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("retgt_done", 32'(done), 32'(i == 9));
      if (i == 5) check("retgt_step2", 32'(lightnum), 32'd2);
      if (i == 8) check("retgt_hold2", 32'(lightnum), 32'd2);
      if (i == 9) check("retgt_step1", 32'(lightnum), 32'd1);
    end
    tick();

    // No-op request equal to the current state.
    send(5'd1, 4'd0);
    check("noop_load_busy", 32'(busy), 32'd1);
    check("noop_load_done", 32'(done), 32'd0);
    tick();
    check("noop_done",      32'(done),     32'd1);
    check("noop_busy_off",  32'(busy),     32'd0);
    check("noop_lightnum",  32'(lightnum), 32'd1);
    tick();
    check("noop_done_off",  32'(done),     32'd0);

    // Asynchronous reset in the middle of a ramp.
    do_reset();
    send(5'd10, 4'd5);
    repeat (29) tick();
    check("midrst_at7",   32'(lightnum), 32'd7);
    check("midrst_shade", 32'(wshade),   32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_zero("midrst");
    #2;
    rst_n = 1'b1;
    tick();
    check_idle_zero("midrst_after");
`else
    // Direct jump: values land one edge after LOAD, done in the same cycle.
    send(5'd9, 4'd3);
    check("direct_load_busy", 32'(busy),      32'd1);
    check("direct_load_num",  32'(lightnum),  32'd0);
    check("direct_load_rdy",  32'(req_ready), 32'd0);
    tick();
    check("direct_lightnum",   32'(lightnum),   32'd9);
    check("direct_wshade",     32'(wshade),     32'd3);
    check("direct_lightstate", 32'(lightstate), 32'h01FF);
    check("direct_done",       32'(done),       32'd1);
    check("direct_busy_off",   32'(busy),       32'd0);
    tick();
    check("direct_done_off",   32'(done),       32'd0);
    check("direct_ready",      32'(req_ready),  32'd1);

    // Clamp above the bank size.
    send(5'd20, 4'd15);
    tick();
    check("clamp_lightnum",   32'(lightnum),   32'd16);
    check("clamp_wshade",     32'(wshade),     32'd15);
    check("clamp_lightstate", 32'(lightstate), 32'hFFFF);
    check("clamp_done",       32'(done),       32'd1);
    tick();

    // Downward jump and a no-op request.
    send(5'd2, 4'd1);
    tick();
    check("down_lightnum",   32'(lightnum),   32'd2);
    check("down_wshade",     32'(wshade),     32'd1);
    check("down_lightstate", 32'(lightstate), 32'h0003);
    tick();
    send(5'd2, 4'd1);
    check("noop_busy",  32'(busy), 32'd1);
    tick();
    check("noop_done",  32'(done), 32'd1);
    check("noop_num",   32'(lightnum), 32'd2);
    tick();

    // Asynchronous reset clears held values.
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_zero("async_rst");
    #2;
    rst_n = 1'b1;
    tick();
    check_idle_zero("async_rst_after");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
